// File: rtl/fixed_float_conv_scheduler_if.sv
// Bundle of the requester, converter and result channels around the shared
// fixed->float converter scheduler. master = scheduler side, slave = clients/converter.
interface fixed_float_conv_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*22-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [21:0]           conv_data;
    logic                  conv_enable;
    logic [31:0]           conv_result;
    logic                  conv_done;
    logic                  res_valid;
    logic                  res_ready;
    logic [31:0]           res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_err;
    logic                  busy;

    modport master (
        input  req_valid, req_data, conv_result, conv_done, res_ready,
        output req_ready, conv_data, conv_enable, res_valid, res_data, res_id, res_err, busy
    );

    modport slave (
        output req_valid, req_data, conv_result, conv_done, res_ready,
        input  req_ready, conv_data, conv_enable, res_valid, res_data, res_id, res_err, busy
    );
endinterface

// File: rtl/fixed_float_conv_scheduler.sv
// Round-robin scheduler sharing one fixed(Q1.20)->float converter between NUM_REQ clients.
// Optional WAIT watchdog enabled by defining FFC_SCHED_WDOG_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | searching for a valid requester from rr_ptr, grant combinational
// ST_ISSUE | first converter-enable cycle, conv_done is stale and ignored
// ST_WAIT  | converter enabled, waiting for conv_done (or watchdog expiry)
// ST_RESP  | result presented on res_*, held until res_ready
module fixed_float_conv_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fixed_float_conv_scheduler_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [1:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] ptr_next;
    logic            grant_found;
    logic [21:0]     req_ops [NUM_REQ];
    logic [21:0]     op_q;
    logic [31:0]     res_data_q;
    logic [ID_W-1:0] res_id_q;
    logic            res_err_q;
    logic            wdog_expired;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ops[i] = bus.req_data[22*i +: 22];
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Grant is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && (state == ST_IDLE) && grant_found) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

`ifdef FFC_SCHED_WDOG_EN
    localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (state == ST_ISSUE) begin
            wdog <= '0;
        end else if (state == ST_WAIT) begin
            wdog <= wdog + 1'b1;
        end
    end

    assign wdog_expired = (wdog == WDOG_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wdog_expired   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            op_q       <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        op_q     <= req_ops[grant_id];
                        res_id_q <= grant_id;
                        rr_ptr   <= ptr_next;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // conv_done takes priority over a simultaneous watchdog expiry
                    if (bus.conv_done) begin
                        res_data_q <= bus.conv_result;
                        res_err_q  <= 1'b0;
                        state      <= ST_RESP;
                    end else if (wdog_expired) begin
                        res_data_q <= QNAN;
                        res_err_q  <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.conv_enable = (state == ST_ISSUE) || (state == ST_WAIT);
    assign bus.conv_data   = op_q;
    assign bus.res_valid   = (state == ST_RESP);
    assign bus.res_data    = res_data_q;
    assign bus.res_id      = res_id_q;
    assign bus.res_err     = res_err_q;
    assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_fixed_float_conv_scheduler.sv
// Directed bench for fixed_float_conv_scheduler with a behavioural converter,
// a transaction-level scoreboard checked every cycle, and literal pins.
module tb_fixed_float_conv_scheduler;
    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fixed_float_conv_scheduler_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

    fixed_float_conv_scheduler #(
        .NUM_REQ(NR), .ID_W(IW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Q1.20 two's complement to IEEE single; exact since 22 bits fit the mantissa.
    function automatic logic [31:0] to_float(input logic [21:0] fx);
        int v, mag, p;
        logic [31:0] f;
        v = int'($signed(fx));
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int b = 0; b < 22; b++) if (mag[b]) p = b;
        f[31]    = (v < 0);
        f[30:23] = 8'(127 + p - 20);
        f[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
        return f;
    endfunction

    function automatic int first_from(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    // Behavioural converter: done after cv_lat enabled cycles, cleared while disabled.
    int          cv_lat   = 3;
    logic        cv_stale = 1'b0;
    int          cv_cnt   = 0;
    logic        cv_en;
    logic [21:0] cv_op;

    initial begin
        bus.conv_done   = 1'b0;
        bus.conv_result = 32'h0;
        forever begin
            @(negedge clk);
            cv_en = bus.conv_enable;
            cv_op = bus.conv_data;
            @(posedge clk);
            #1;
            if (!cv_en) begin
                cv_cnt = 0;
                bus.conv_done = cv_stale;
            end else begin
                cv_cnt++;
                if (cv_cnt >= cv_lat) begin
                    bus.conv_result = to_float(cv_op);
                    bus.conv_done   = 1'b1;
                end else begin
                    bus.conv_done = 1'b0;
                end
            end
        end
    end

    // Transaction model and per-cycle compare
    logic        m_busy = 1'b0;
    int          m_ptr  = 0;
    int          m_id   = 0;
    logic [21:0] m_op   = '0;
    logic        m_err  = 1'b0;
    int          m_acc_cyc = 0;
    logic        m_seen_res = 1'b0;
    logic        tmo_expected = 1'b0;
    int          g;
    int          last_lat = 0;
    int          resp_count = 0;
    logic [31:0] last_res_data = '0;
    logic [31:0] last_res_id = '0;
    logic        last_res_err = 1'b0;
    logic [NR-1:0] acc_log [$];
    int            acc_cyc [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            g = first_from(bus.req_valid, m_ptr);
            check("idle_req_ready", 32'(bus.req_ready), (g < 0) ? 32'h0 : (32'h1 << g));
            check("idle_busy", 32'(bus.busy), 32'h0);
            check("idle_res_valid", 32'(bus.res_valid), 32'h0);
            check("idle_conv_enable", 32'(bus.conv_enable), 32'h0);
            if (g >= 0) begin
                m_busy     = 1'b1;
                m_id       = g;
                m_op       = bus.req_data[22*g +: 22];
                m_err      = tmo_expected;
                m_ptr      = (g + 1) % NR;
                m_acc_cyc  = cyc;
                m_seen_res = 1'b0;
                acc_log.push_back(bus.req_ready);
                acc_cyc.push_back(cyc);
            end
        end else begin
            check("busy_req_ready", 32'(bus.req_ready), 32'h0);
            check("busy_flag", 32'(bus.busy), 32'h1);
            if (bus.conv_enable) check("conv_data", 32'(bus.conv_data), 32'(m_op));
            if (bus.res_valid) begin
                check("res_data", bus.res_data, m_err ? 32'h7FC0_0000 : to_float(m_op));
                check("res_id", 32'(bus.res_id), 32'(m_id));
                check("res_err", 32'(bus.res_err), 32'(m_err));
                check("resp_conv_enable", 32'(bus.conv_enable), 32'h0);
                if (!m_seen_res) begin
                    last_lat   = cyc - m_acc_cyc;
                    m_seen_res = 1'b1;
                end
                if (bus.res_ready) begin
                    last_res_data = bus.res_data;
                    last_res_id   = 32'(bus.res_id);
                    last_res_err  = bus.res_err;
                    m_busy = 1'b0;
                    resp_count++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [21:0] d);
        bus.req_data[22*i +: 22] = d;
    endtask

    task automatic wait_resp(input int target, input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #2;
            if (resp_count >= target) break;
        end
        check(name, 32'(resp_count), 32'(target));
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        bus.req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
        check({tag, "_conv_enable"}, 32'(bus.conv_enable), 32'h0);
        check({tag, "_conv_data"}, 32'(bus.conv_data), 32'h0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'h0);
        check({tag, "_res_data"}, bus.res_data, 32'h0);
        check({tag, "_res_id"}, 32'(bus.res_id), 32'h0);
        check({tag, "_res_err"}, 32'(bus.res_err), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        int nacc;
        logic [NR-1:0] exp_grants [5];
        exp_grants[0] = 4'b0001; exp_grants[1] = 4'b0010; exp_grants[2] = 4'b0100;
        exp_grants[3] = 4'b1000; exp_grants[4] = 4'b0001;

        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        #12;
        check_all_zero("reset");

        check("model_pos1", to_float(22'h100000), 32'h3F80_0000);
        check("model_neg1", to_float(22'h300000), 32'hBF80_0000);
        check("model_half", to_float(22'h080000), 32'h3F00_0000);
        check("model_neg2", to_float(22'h200000), 32'hC000_0000);
        check("model_zero", to_float(22'h000000), 32'h0000_0000);

        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        tick();

        // 1: single +1.0, converter done after 3 enabled cycles
        cv_lat = 3;
        bus.res_ready = 1'b1;
        set_req(0, 22'h100000);
        base = resp_count;
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        wait_resp(base + 1, 40, "t1_resp");
        check("t1_latency", 32'(last_lat), 32'd5);
        check("t1_data", last_res_data, 32'h3F80_0000);
        check("t1_id", last_res_id, 32'd0);
        check("t1_err", 32'(last_res_err), 32'h0);

        // 2: all requesters valid, rotation 0,1,2,3,0 at 4-cycle spacing
        do_reset();
        cv_lat = 1;
        set_req(0, 22'h080000);
        set_req(1, 22'h200000);
        set_req(2, 22'h000000);
        set_req(3, 22'h0C0000);
        acc_log.delete();
        acc_cyc.delete();
        base = resp_count;
        bus.req_valid = 4'b1111;
        wait_resp(base + 5, 60, "t2_resp");
        bus.req_valid = '0;
        nacc = acc_log.size();
        check("t2_accepts", 32'(nacc), 32'd5);
        for (int i = 0; i < 5 && i < nacc; i++) check("t2_grant", 32'(acc_log[i]), 32'(exp_grants[i]));
        for (int i = 0; i < 4 && i + 1 < nacc; i++) check("t2_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd4);
        check("t3_model_075", to_float(22'h0C0000), 32'h3F40_0000);

        // 3: result back-pressure for 10 cycles, then release
        do_reset();
        cv_lat = 2;
        bus.res_ready = 1'b0;
        set_req(1, 22'h040000);
        set_req(0, 22'h0C0000);
        base = resp_count;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0001;
        for (int n = 0; n < 40 && !bus.res_valid; n++) tick();
        check("t3_res_valid", 32'(bus.res_valid), 32'h1);
        repeat (10) tick();
        check("t3_hold_data", bus.res_data, 32'h3E80_0000);
        check("t3_hold_id", 32'(bus.res_id), 32'd1);
        check("t3_hold_ready", 32'(bus.req_ready), 32'h0);
        check("t3_hold_en", 32'(bus.conv_enable), 32'h0);
        bus.res_ready = 1'b1;
        tick();
        check("t3_idle_busy", 32'(bus.busy), 32'h0);
        check("t3_idle_valid", 32'(bus.res_valid), 32'h0);
        check("t3_next_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        wait_resp(base + 2, 40, "t3_resp");
        check("t3_second_data", last_res_data, 32'h3F40_0000);

        // 4: asynchronous reset in WAIT; rr_ptr returns to 0
        do_reset();
        cv_lat = 1000;
        set_req(2, 22'h0A0000);
        set_req(3, 22'h010000);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        repeat (5) tick();
        check("t4_busy_before", 32'(bus.busy), 32'h1);
        bus.req_valid = 4'b1100;
        rst_n = 1'b0;
        #1;
        check_all_zero("t4_reset");
        tick();
        cv_lat = 1;
        tick();
        rst_n = 1'b1;
        #1;
        check("t4_grant_after", 32'(bus.req_ready), 32'b0100);
        base = resp_count;
        tick();
        bus.req_valid = '0;
        wait_resp(base + 1, 40, "t4_resp");
        check("t4_id", last_res_id, 32'd2);
        check("t4_data", last_res_data, 32'h3F20_0000);

        // 5: converter never completes
        do_reset();
        cv_lat = 1000;
        set_req(3, 22'h100000);
`ifdef FFC_SCHED_WDOG_EN
        tmo_expected = 1'b1;
        base = resp_count;
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        tmo_expected = 1'b0;
        wait_resp(base + 1, 60, "t5_resp");
        check("t5_latency", 32'(last_lat), 32'd10);
        check("t5_data", last_res_data, 32'h7FC0_0000);
        check("t5_err", 32'(last_res_err), 32'h1);
        cv_lat = TMO;
        set_req(1, 22'h100000);
        base = resp_count;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        wait_resp(base + 1, 60, "t5_tie_resp");
        check("t5_tie_latency", 32'(last_lat), 32'd10);
        check("t5_tie_data", last_res_data, 32'h3F80_0000);
        check("t5_tie_err", 32'(last_res_err), 32'h0);
`else
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        repeat (40) tick();
        check("t5_stuck_busy", 32'(bus.busy), 32'h1);
        check("t5_stuck_valid", 32'(bus.res_valid), 32'h0);
        check("t5_stuck_err", 32'(bus.res_err), 32'h0);
        do_reset();
`endif

        // 6: stale conv_done during ISSUE must not be captured
        cv_lat = 3;
        cv_stale = 1'b1;
        tick();
        tick();
        set_req(0, 22'h300000);
        base = resp_count;
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        wait_resp(base + 1, 40, "t6_resp");
        check("t6_data", last_res_data, 32'hBF80_0000);
        check("t6_latency", 32'(last_lat), 32'd5);
        cv_stale = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
